// File: rtl/snake_pkg.sv
// snake_pkg: shared snake-game constants (coordinate width, tile size, food FSM state encoding)
package snake_pkg;
  localparam int COORD_W = 10;
  localparam int TILE_PX = 20;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_CHECK  = 2'd3;
endpackage

// File: rtl/tile_overlap.sv
// tile_overlap: combinational |a-b| < TILE test on two coordinate pairs (ports: ax, ay, bx, by in; hit out)
module tile_overlap
  import snake_pkg::*;
#(
  parameter int BIT  = COORD_W,
  parameter int TILE = TILE_PX
)(
  input  logic [BIT-1:0] ax,
  input  logic [BIT-1:0] ay,
  input  logic [BIT-1:0] bx,
  input  logic [BIT-1:0] by,
  output logic           hit
);
  logic [BIT:0] dx, dy, adx, ady;
  always_comb begin
    dx  = {1'b0, ax} - {1'b0, bx};
    dy  = {1'b0, ay} - {1'b0, by};
    adx = dx[BIT] ? -dx : dx;
    ady = dy[BIT] ? -dy : dy;
    hit = (adx < (BIT+1)'(TILE)) && (ady < (BIT+1)'(TILE));
  end
endmodule

// File: rtl/food_controller.sv
// food_controller: owns food position, re-rolls on body collision, pulses grow on eat.
// Ports: clk, rst_n (async active-low), tick, head_x/y in; new_number_trigger out, rand_x/y in;
// chk_req/chk_x/chk_y out, chk_ack/chk_hit in; food_x/y, grow, busy, score out.
// Optional FOOD_SCORE_EN: builds a saturating 8-bit eaten-food counter; otherwise score is 0.
module food_controller
  import snake_pkg::*;
#(
  parameter int BIT       = COORD_W,
  parameter int TILE      = TILE_PX,
  parameter int INIT_X    = 60,
  parameter int INIT_Y    = 100,
  parameter int MAX_RETRY = 7
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [BIT-1:0] head_x,
  input  logic [BIT-1:0] head_y,
  input  logic [BIT-1:0] rand_x,
  input  logic [BIT-1:0] rand_y,
  output logic           new_number_trigger,
  output logic           chk_req,
  output logic [BIT-1:0] chk_x,
  output logic [BIT-1:0] chk_y,
  input  logic           chk_ack,
  input  logic           chk_hit,
  output logic [BIT-1:0] food_x,
  output logic [BIT-1:0] food_y,
  output logic           grow,
  output logic           busy,
  output logic [7:0]     score
);
  localparam int RW = ($clog2(MAX_RETRY + 1) < 3) ? 3 : $clog2(MAX_RETRY + 1);
  logic [1:0]     state_q, state_d;
  logic [BIT-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [BIT-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           grow_q, grow_d;
  logic           eat;
  tile_overlap #(.BIT(BIT), .TILE(TILE)) u_overlap (
    .ax(head_x), .ay(head_y), .bx(food_x_q), .by(food_y_q), .hit(eat)
  );
  always_comb begin
    state_d  = state_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    retry_d  = retry_q;
    grow_d   = 1'b0;
    case (state_q)
      ST_IDLE:   state_d = (tick && eat) ? ST_REQ : ST_IDLE;
      ST_REQ:    state_d = ST_SETTLE;
      ST_SETTLE: begin
        cand_x_d = rand_x;
        cand_y_d = rand_y;
        state_d  = ST_CHECK;
      end
      default: if (chk_ack) begin
        if (chk_hit && retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_REQ;
        end else begin
          food_x_d = cand_x_q;
          food_y_d = cand_y_q;
          grow_d   = 1'b1;
          retry_d  = '0;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cand_x_q <= '0;
      cand_y_q <= '0;
      food_x_q <= BIT'(INIT_X);
      food_y_q <= BIT'(INIT_Y);
      retry_q  <= '0;
      grow_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
      retry_q  <= retry_d;
      grow_q   <= grow_d;
    end
  end
`ifdef FOOD_SCORE_EN
  logic [7:0] score_q, score_d;
  always_comb score_d = (grow_d && !(&score_q)) ? score_q + 8'd1 : score_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) score_q <= '0;
    else        score_q <= score_d;
  end
  assign score = score_q;
`else
  assign score = '0;
`endif
  // Trigger and query are pure decodes of the state flop, so they are glitch-free and drop on async reset.
  assign new_number_trigger = (state_q == ST_REQ);
  assign chk_req            = (state_q == ST_CHECK);
  assign chk_x              = cand_x_q;
  assign chk_y              = cand_y_q;
  assign food_x             = food_x_q;
  assign food_y             = food_y_q;
  assign grow               = grow_q;
  assign busy               = (state_q != ST_IDLE);
endmodule

// File: tb/tb_food_controller.sv
// tb_food_controller: table-driven and directed-sequence check of food_controller
module tb_food_controller;
  logic       clk = 1'b0;
  logic       rst_n, tick, chk_ack, chk_hit;
  logic [9:0] head_x, head_y, rand_x, rand_y;
  logic       trig, chk_req, grow, busy;
  logic [9:0] chk_x, chk_y, food_x, food_y;
  logic [7:0] score;
  int n_chk = 0;
  int n_fail = 0;
  int exp_score = 0;
  always #5 clk = ~clk;
  food_controller dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .head_x(head_x), .head_y(head_y),
    .rand_x(rand_x), .rand_y(rand_y), .new_number_trigger(trig), .chk_req(chk_req),
    .chk_x(chk_x), .chk_y(chk_y), .chk_ack(chk_ack), .chk_hit(chk_hit),
    .food_x(food_x), .food_y(food_y), .grow(grow), .busy(busy), .score(score)
  );
  typedef struct {
    logic       tick;
    logic [9:0] hx, hy, rx, ry;
    logic       ack, hit;
    logic       trig, req, grow, busy;
    logic [9:0] cx, cy, fx, fy;
  } vec_t;
  vec_t v[21];
  function automatic vec_t mk(logic t, int hx, int hy, int rx, int ry, logic a, logic h,
                              logic et, logic er, logic eg, logic eb, int cx, int cy, int fx, int fy);
    vec_t r;
    r.tick = t; r.hx = 10'(hx); r.hy = 10'(hy); r.rx = 10'(rx); r.ry = 10'(ry);
    r.ack = a; r.hit = h; r.trig = et; r.req = er; r.grow = eg; r.busy = eb;
    r.cx = 10'(cx); r.cy = 10'(cy); r.fx = 10'(fx); r.fy = 10'(fy);
    return r;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic bump_score();
`ifdef FOOD_SCORE_EN
    if (exp_score < 255) exp_score++;
`endif
  endtask
  initial begin
    int ntrig, prev_trig, consec, ngrow, got;
    // inputs; expected after the edge: trig req grow busy chk_x/y food_x/y
    v[0]  = mk(1, 300, 300,   0,   0, 0, 0, 0, 0, 0, 0,   0,   0,  60, 100);
    v[1]  = mk(1,  70, 110, 200, 150, 0, 0, 1, 0, 0, 1,   0,   0,  60, 100);
    v[2]  = mk(0,  70, 110, 200, 150, 0, 0, 0, 0, 0, 1,   0,   0,  60, 100);
    v[3]  = mk(0,  70, 110, 200, 150, 0, 0, 0, 1, 0, 1, 200, 150,  60, 100);
    v[4]  = mk(0,  70, 110, 200, 150, 1, 0, 0, 0, 1, 0, 200, 150, 200, 150);
    v[5]  = mk(0,  70, 110, 200, 150, 0, 0, 0, 0, 0, 0, 200, 150, 200, 150);
    v[6]  = mk(1, 205, 140, 300, 200, 0, 0, 1, 0, 0, 1, 200, 150, 200, 150);
    v[7]  = mk(0, 205, 140, 300, 200, 0, 0, 0, 0, 0, 1, 200, 150, 200, 150);
    v[8]  = mk(0, 205, 140, 300, 200, 0, 0, 0, 1, 0, 1, 300, 200, 200, 150);
    v[9]  = mk(0, 205, 140, 240, 160, 1, 1, 1, 0, 0, 1, 300, 200, 200, 150);
    v[10] = mk(0, 205, 140, 240, 160, 0, 0, 0, 0, 0, 1, 300, 200, 200, 150);
    v[11] = mk(0, 205, 140, 240, 160, 0, 0, 0, 1, 0, 1, 240, 160, 200, 150);
    v[12] = mk(0, 205, 140, 240, 160, 1, 0, 0, 0, 1, 0, 240, 160, 240, 160);
    v[13] = mk(1, 220, 160, 240, 160, 0, 0, 0, 0, 0, 0, 240, 160, 240, 160);
    v[14] = mk(1, 260, 160, 240, 160, 1, 0, 0, 0, 0, 0, 240, 160, 240, 160);
    v[15] = mk(1, 221, 179, 100,  50, 0, 0, 1, 0, 0, 1, 240, 160, 240, 160);
    v[16] = mk(1, 221, 179, 100,  50, 1, 0, 0, 0, 0, 1, 240, 160, 240, 160);
    v[17] = mk(1, 221, 179, 100,  50, 1, 0, 0, 1, 0, 1, 100,  50, 240, 160);
    v[18] = mk(0, 221, 179, 100,  50, 0, 0, 0, 1, 0, 1, 100,  50, 240, 160);
    v[19] = mk(1, 221, 179, 100,  50, 1, 0, 0, 0, 1, 0, 100,  50, 100,  50);
    v[20] = mk(1, 221, 179, 100,  50, 0, 0, 0, 0, 0, 0, 100,  50, 100,  50);
    rst_n = 1'b0; tick = 1'b0; chk_ack = 1'b0; chk_hit = 1'b0;
    head_x = '0; head_y = '0; rand_x = '0; rand_y = '0;
    repeat (2) step();
    chk("rst_food_x", food_x, 60);
    chk("rst_food_y", food_y, 100);
    chk("rst_trig", trig, 0);
    chk("rst_req", chk_req, 0);
    chk("rst_grow", grow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_score", score, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick = v[i].tick; head_x = v[i].hx; head_y = v[i].hy;
      rand_x = v[i].rx; rand_y = v[i].ry; chk_ack = v[i].ack; chk_hit = v[i].hit;
      step();
      if (v[i].grow) bump_score();
      chk($sformatf("v%0d_trig", i), trig, v[i].trig);
      chk($sformatf("v%0d_req", i), chk_req, v[i].req);
      chk($sformatf("v%0d_grow", i), grow, v[i].grow);
      chk($sformatf("v%0d_busy", i), busy, v[i].busy);
      chk($sformatf("v%0d_chk_x", i), chk_x, v[i].cx);
      chk($sformatf("v%0d_chk_y", i), chk_y, v[i].cy);
      chk($sformatf("v%0d_food_x", i), food_x, v[i].fx);
      chk($sformatf("v%0d_food_y", i), food_y, v[i].fy);
      chk($sformatf("v%0d_score", i), score, exp_score);
    end
    // every query reports a body hit: 8 requests, then forced accept of the last candidate
    head_x = 100; head_y = 50; rand_x = 300; rand_y = 200;
    tick = 1'b1; chk_ack = 1'b1; chk_hit = 1'b1;
    ntrig = 0; prev_trig = 0; consec = 0; got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      step();
      tick = 1'b0;
      if (trig) begin
        ntrig++;
        if (prev_trig) consec++;
        rand_x = 10'(300 + 10 * ntrig);
        rand_y = 10'(200 + ntrig);
      end
      prev_trig = int'(trig);
      if (grow) got = 1;
    end
    bump_score();
    chk("allhit_grow_seen", got, 1);
    chk("allhit_trig_pulses", ntrig, 8);
    chk("allhit_trig_back_to_back", consec, 0);
    chk("allhit_food_x", food_x, 380);
    chk("allhit_food_y", food_y, 208);
    chk("allhit_score", score, exp_score);
    // tick held high through a whole eat: exactly one grow
    head_x = 380; head_y = 208; rand_x = 500; rand_y = 400;
    tick = 1'b1; chk_ack = 1'b1; chk_hit = 1'b0; ngrow = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (grow) ngrow++;
    end
    bump_score();
    chk("tickhold_grows", ngrow, 1);
    chk("tickhold_food_x", food_x, 500);
    chk("tickhold_score", score, exp_score);
    // 300 eats, alternating replacement positions
    ngrow = 0;
    for (int i = 0; i < 300; i++) begin
      head_x = food_x; head_y = food_y;
      rand_x = (i % 2 == 0) ? 10'd100 : 10'd500;
      rand_y = (i % 2 == 0) ? 10'd300 : 10'd400;
      tick = 1'b1;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        step();
        tick = 1'b0;
        if (grow) got = 1;
      end
      if (got) begin
        ngrow++;
        bump_score();
      end
    end
    tick = 1'b0;
    step();
    chk("eat300_grows", ngrow, 300);
    chk("eat300_food_x", food_x, 500);
    chk("eat300_score", score, exp_score);
    // reset dropped while a query is pending
    head_x = 500; head_y = 400; rand_x = 10; rand_y = 20;
    chk_ack = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    chk("midrst_in_check", chk_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", chk_req, 0);
    chk("midrst_trig", trig, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grow", grow, 0);
    chk("midrst_food_x", food_x, 60);
    chk("midrst_food_y", food_y, 100);
    chk("midrst_score", score, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_busy", busy, 0);
    chk("postrst_food_x", food_x, 60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/food_controller.md
# food_controller

Owns the food (apple) position in the snake game. Each game tick it checks whether the snake head overlaps the food. On a hit it requests a fresh coordinate from the upstream `random_position` generator by pulsing its trigger, and asks the snake body store whether that coordinate is occupied, re-rolling when it is. It then commits the new food position and emits a one-cycle `grow` pulse to the snake datapath.

## Interface
- `BIT`, 10: coordinate width
- `TILE`, 20: food/head size in pixels; overlap test window
- `INIT_X`, 60: food x after reset (matches generator's reset output)
- `INIT_Y`, 100: food y after reset
- `MAX_RETRY`, 7: body-collision re-rolls before forced accept
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `tick`  in  1  one-cycle game-update strobe
- `head_x`, `head_y`  in  BIT  snake head position, stable while `tick` high
- `rand_x`, `rand_y`  in  BIT  generator outputs
- `new_number_trigger`  out  1  request to generator (rising edge sampled)
- `chk_req`  out  1  body-occupancy query valid
- `chk_x`, `chk_y`  out  BIT  queried coordinate
- `chk_ack`  in  1  query answered (one-cycle)
- `chk_hit`  in  1  queried coordinate lies on the body; valid with `chk_ack`
- `food_x`, `food_y`  out  BIT  current food position
- `grow`  out  1  one-cycle pulse: food eaten and replaced
- `busy`  out  1  high whenever state is not IDLE
- `score`  out  8  eaten-food count

## Operation
- States: IDLE, REQ, SETTLE, CHECK.
- IDLE: on `tick`, if |head_x−food_x| < TILE and |head_y−food_y| < TILE (unsigned operands, differences computed at BIT+1 bits), go to REQ. Otherwise remain in IDLE.
- REQ: `new_number_trigger`=1 for exactly one cycle; go to SETTLE.
- SETTLE: trigger=0, which guarantees the low phase the generator's edge detector needs. Latch `rand_x/rand_y` into the candidate register; go to CHECK.
- CHECK: `chk_req`=1 with `chk_x/chk_y` equal to the candidate, held until `chk_ack`.
  - On ack with `chk_hit`=1 and retry < MAX_RETRY: increment retry; go to REQ.
  - Otherwise: food ← candidate, `grow`=1 for one cycle, score update, retry ← 0; go to IDLE.
- `tick` outside IDLE is ignored; an eat is never queued.
- `chk_ack` outside CHECK is ignored.
- Retry counter is 3 bits min, sized for MAX_RETRY.

## Timing
- Reset values: state IDLE, `food_x`=INIT_X, `food_y`=INIT_Y, trigger/`chk_req`/`grow`/`busy`=0, `score`=0, retry=0.
- Minimum eat-to-grow latency with `chk_ack` returned in the first CHECK cycle:
  - tick in cycle t
  - REQ in t+1
  - SETTLE in t+2
  - CHECK plus ack in t+3
  - `grow` high and `food_*` updated in t+4
- Each re-roll adds 3 cycles plus the ack wait.
- `new_number_trigger` is registered and never high in two consecutive cycles.
- `food_*` change only on the `grow` cycle.
- `rst_n` asserted mid-operation: immediate return to reset values. Any pending query is dropped; the body store must tolerate an abandoned `chk_req`.
- `tick` coinciding with `grow` (last CHECK cycle): ignored, because state is not IDLE.

## Configuration
- `FOOD_SCORE_EN` defined: `score` increments on every `grow` and saturates at 255.
- Undefined: no counter is built and `score` is tied to 0.

## Structure
- Shared package `snake_pkg`: the state encoding, TILE default, and coordinate width default. These are shared with the snake datapath and VGA renderer.
- One sub-module, `tile_overlap`: combinational |a−b|<TILE test on two coordinate pairs. It is reusable by the self-collision logic.

## Test plan
- Reset, then `tick` with head (300,300) -> no trigger, food stays (60,100), `busy`=0.
- `tick` with head (70,110), rand=(200,150), `chk_ack`+`chk_hit`=0 in the first CHECK cycle -> trigger in t+1 only, `chk_x/y`=(200,150) in t+3, `grow` and food=(200,150) in t+4.
- Same, first ack with `chk_hit`=1 and second with `chk_hit`=0, rand changing to (240,160) -> second trigger pulse separated by at least one low cycle, final food (240,160).
- `chk_hit`=1 on every ack -> exactly 8 trigger pulses, then forced accept of the last candidate and `grow`.
- `tick` asserted every cycle during an eat sequence -> exactly one `grow`; `score` +1 with `FOOD_SCORE_EN`, 0 without; 300 eats -> `score`=255.
- `rst_n` dropped while in CHECK -> outputs return to reset values asynchronously, `chk_req` falls before the next clock edge.
